// File: rtl/pow_5_arb_pkg.sv
// Shared types and helpers for the x^5 round-robin arbiter.
// The optional WAIT watchdog is enabled with POW5_ARB_TIMEOUT_EN.
package pow_5_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Requester-index width; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pow_5_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, find lowest set bit, rotate back.
module pow_5_rr_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   tmp;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        tmp   = rot;
        off   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!any && tmp[0]) begin
                any = 1'b1;
                off = ID_W'(k);
            end
            tmp = tmp >> 1;
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx   = sum[ID_W-1:0];
        grant = N_REQ'(any) << idx;
    end

endmodule

// File: rtl/pow_5_rr_arbiter.sv
// Round-robin front end sharing one external x^5 unit among N_REQ requesters.
// Define POW5_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns an error response.
module pow_5_rr_arbiter
    import pow_5_arb_pkg::*;
#(
    parameter int unsigned w       = 8,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    localparam int unsigned ID_W   = id_w(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ*w-1:0] req_n,
    output logic [N_REQ-1:0]   req_rdy,
    output logic               rsp_vld,
    output logic [ID_W-1:0]    rsp_id,
    output logic [w-1:0]       rsp_res,
    output logic               rsp_err,
    output logic               busy,
    output logic               unit_n_vld,
    output logic [w-1:0]       unit_n,
    input  logic               unit_res_vld,
    input  logic [w-1:0]       unit_res
);

    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [w-1:0]    unit_n_d;
    logic            rsp_vld_d, rsp_err_d;
    logic [ID_W-1:0] rsp_id_d;
    logic [w-1:0]    rsp_res_d;

    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;

`ifdef POW5_ARB_TIMEOUT_EN
    localparam int unsigned   CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    pow_5_rr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req_vld),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state, handshake and response logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        unit_n_d  = unit_n;
        req_rdy   = '0;
        rsp_vld_d = 1'b0;
        rsp_err_d = 1'b0;
        rsp_id_d  = rsp_id;
        rsp_res_d = rsp_res;
`ifdef POW5_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_rdy  = pick_grant;
                    gnt_d    = pick_idx;
                    unit_n_d = w'(req_n >> (32'(pick_idx) * w));
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef POW5_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (unit_res_vld) begin
                    rsp_vld_d = 1'b1;
                    rsp_id_d  = gnt_q;
                    rsp_res_d = unit_res;
                    ptr_d     = (gnt_q == ID_LAST) ? '0 : gnt_q + 1'b1;
                    state_d   = IDLE;
                end
`ifdef POW5_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LIM) begin
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b1;
                    rsp_id_d  = gnt_q;
                    rsp_res_d = '0;
                    ptr_d     = (gnt_q == ID_LAST) ? '0 : gnt_q + 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            unit_n     <= '0;
            unit_n_vld <= 1'b0;
            busy       <= 1'b0;
            rsp_vld    <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_id     <= '0;
            rsp_res    <= '0;
`ifdef POW5_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            unit_n     <= unit_n_d;
            unit_n_vld <= (state_d == ISSUE);
            busy       <= (state_d != IDLE);
            rsp_vld    <= rsp_vld_d;
            rsp_err    <= rsp_err_d;
            rsp_id     <= rsp_id_d;
            rsp_res    <= rsp_res_d;
`ifdef POW5_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_pow_5_rr_arbiter.sv
// Directed bench for pow_5_rr_arbiter with a simple 6-cycle x^5 unit model.
module tb_pow_5_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [31:0] req_n;
    logic [3:0]  req_rdy;
    logic        rsp_vld;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_res;
    logic        rsp_err;
    logic        busy;
    logic        unit_n_vld;
    logic [7:0]  unit_n;
    logic        unit_res_vld;
    logic [7:0]  unit_res;

    logic        unit_auto;
    logic        model_vld;
    logic [7:0]  model_x;
    int          model_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pow_5_rr_arbiter #(.w(8), .N_REQ(4), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_n        (req_n),
        .req_rdy      (req_rdy),
        .rsp_vld      (rsp_vld),
        .rsp_id       (rsp_id),
        .rsp_res      (rsp_res),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .unit_n_vld   (unit_n_vld),
        .unit_n       (unit_n),
        .unit_res_vld (unit_res_vld),
        .unit_res     (unit_res)
    );

    function automatic logic [7:0] pow5(input logic [7:0] x);
        logic [7:0] r;
        r = x * x;
        r = r * r;
        r = r * x;
        return r;
    endfunction

    // Unit model: result valid six cycles after the n_vld cycle.
    initial begin
        model_vld = 1'b0;
        model_x   = '0;
        model_cnt = 0;
        unit_res  = '0;
    end
    always @(posedge clk) begin
        model_vld <= 1'b0;
        if (unit_auto) begin
            if (unit_n_vld) begin
                model_x   <= unit_n;
                model_cnt <= 5;
            end else if (model_cnt > 0) begin
                model_cnt <= model_cnt - 1;
                if (model_cnt == 1) begin
                    model_vld <= 1'b1;
                    unit_res  <= pow5(model_x);
                end
            end
        end
    end
    assign unit_res_vld = unit_auto & model_vld;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(inout int cyc);
        while (!rsp_vld && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        #1;
        while (req_rdy == 4'b0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    // One isolated transaction on requester id; latency measured from accept cycle.
    task automatic single(input int id, input logic [7:0] n, input int exp_res,
                          input int exp_lat, input int exp_err);
        int cyc;
        @(negedge clk);
        req_vld = 4'b0001 << id;
        req_n[id*8 +: 8] = n;
        #1;
        chk("rdy_grant", int'(req_rdy), 1 << id);
        @(negedge clk);
        req_vld = 4'b0;
        chk("issue_vld", int'(unit_n_vld), 1);
        chk("issue_n", int'(unit_n), int'(n));
        chk("busy", int'(busy), 1);
        cyc = 1;
        wait_rsp(cyc);
        chk("latency", cyc, exp_lat);
        chk("rsp_id", int'(rsp_id), id);
        chk("rsp_res", int'(rsp_res), exp_res);
        chk("rsp_err", int'(rsp_err), exp_err);
        @(negedge clk);
        chk("rsp_pulse", int'(rsp_vld), 0);
    endtask

    initial begin
        int cyc;
        int seen;
        int order [4];
        int expr  [4];

        rst_n     = 1'b0;
        req_vld   = '0;
        req_n     = '0;
        unit_auto = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rdy", int'(req_rdy), 0);
        chk("rst_rsp", int'({rsp_vld, rsp_err, busy, unit_n_vld}), 0);
        chk("rst_id_res", int'({rsp_id, rsp_res}), 0);
        chk("rst_unit_n", int'(unit_n), 0);

        // Single requests; last lands on id 3 so ptr wraps to 0.
        single(0, 8'd3, 243, 8, 0);
        single(1, 8'd5, 53, 8, 0);
        single(3, 8'd2, 32, 8, 0);

        // All four requesters with ptr = 0: strict ID order.
        order = '{0, 1, 2, 3};
        expr  = '{1, 32, 243, 0};
        @(negedge clk);
        req_n   = {8'd4, 8'd3, 8'd2, 8'd1};
        req_vld = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_rdy();
            chk("all_grant", int'(req_rdy), 1 << order[k]);
            @(negedge clk);
            req_vld[order[k]] = 1'b0;
            chk("all_hold_rdy", int'(req_rdy), 0);
            cyc = 1;
            wait_rsp(cyc);
            chk("all_lat", cyc, 8);
            chk("all_id", int'(rsp_id), order[k]);
            chk("all_res", int'(rsp_res), expr[k]);
        end
        req_vld = 4'b1111;
        #1;
        chk("wrap_grant", int'(req_rdy), 1);
        @(negedge clk);
        req_vld = 4'b0;
        cyc = 1;
        wait_rsp(cyc);
        chk("wrap_id", int'(rsp_id), 0);
        chk("wrap_res", int'(rsp_res), 1);

        // ptr is now 1; one grant to id 1 moves it to 2.
        single(1, 8'd1, 1, 8, 0);

        // Fairness from ptr = 2 with req_vld = 1011: 3, then 0, then 1.
        order = '{3, 0, 1, 0};
        expr  = '{32, 53, 243, 0};
        @(negedge clk);
        req_n   = {8'd2, 8'd0, 8'd3, 8'd5};
        req_vld = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_rdy();
            chk("fair_grant", int'(req_rdy), 1 << order[k]);
            @(negedge clk);
            req_vld[order[k]] = 1'b0;
            cyc = 1;
            wait_rsp(cyc);
            chk("fair_id", int'(rsp_id), order[k]);
            chk("fair_res", int'(rsp_res), expr[k]);
        end

        // Reset in WAIT: late unit result must not produce a response.
        @(negedge clk);
        req_vld = 4'b0100;
        req_n[23:16] = 8'd3;
        @(negedge clk);
        req_vld = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_wait_busy", int'(busy), 0);
        chk("rst_wait_nvld", int'(unit_n_vld), 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_vld) seen++;
        end
        chk("rst_wait_drop", seen, 0);
        chk("rst_wait_idle", int'(busy), 0);

        // ptr back at 0 after reset: id 2 is the only requester.
        single(2, 8'd2, 32, 8, 0);

`ifdef POW5_ARB_TIMEOUT_EN
        unit_auto = 1'b0;
        single(3, 8'd7, 0, 17, 1);
        unit_auto = 1'b1;
        single(0, 8'd3, 243, 8, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
